// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester-side request/grant bus shared by UART, decoder and VGA.
interface sram_access_arbiter_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] rvalid;
  logic [17:0] uart_address;
  logic [15:0] uart_write_data;
  logic uart_we_n;
  logic [17:0] dec_address;
  logic [15:0] dec_write_data;
  logic dec_we_n;
  logic [17:0] vga_address;
  modport master (
    output req, uart_address, uart_write_data, uart_we_n,
    output dec_address, dec_write_data, dec_we_n, vga_address,
    input grant, rvalid
  );
  modport slave (
    input req, uart_address, uart_write_data, uart_we_n,
    input dec_address, dec_write_data, dec_we_n, vga_address,
    output grant, rvalid
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: registered request/grant scheduler sharing one SRAM_Controller port (UART > decoder > VGA).
// Define ARB_STATS_EN to add per-requester grant_cycles and max_wait counters.
module sram_access_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST = 64
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  sram_access_arbiter_if.slave bus,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic SRAM_we_n,
  output logic arb_busy
`ifdef ARB_STATS_EN
  ,
  output logic [2:0][31:0] grant_cycles,
  output logic [2:0][15:0] max_wait
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
  typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_OWN, S_ARB_TURN} state_t;
  state_t state;
  logic [2:0] grant, last_owner, contenders, fair_req;
  logic [CW-1:0] burst_cnt;
  logic [3:0] stage [READ_LATENCY];

  function automatic logic [2:0] pick(input logic [2:0] r);
    return r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
  endfunction

  assign contenders = bus.req & ~grant;
  // the last preempted owner sits out one arbitration if anyone else is waiting
  assign fair_req = (bus.req & ~last_owner) != 3'b000 ? bus.req & ~last_owner : bus.req;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state <= S_ARB_IDLE;
      grant <= 3'b000;
      burst_cnt <= '0;
      last_owner <= 3'b000;
    end else begin
      case (state)
        S_ARB_IDLE: if (bus.req != 3'b000) begin
          grant <= pick(bus.req);
          burst_cnt <= '0;
          state <= S_ARB_OWN;
        end
        S_ARB_OWN: if ((bus.req & grant) == 3'b000) begin
          grant <= 3'b000;
          state <= S_ARB_TURN;
        end else if (burst_cnt == CAP && contenders != 3'b000) begin
          grant <= 3'b000;
          last_owner <= grant;
          state <= S_ARB_TURN;
        end else begin
          burst_cnt <= burst_cnt == CAP ? CAP : burst_cnt + 1'b1;
        end
        S_ARB_TURN: if (bus.req != 3'b000) begin
          grant <= pick(fair_req);
          burst_cnt <= '0;
          state <= S_ARB_OWN;
        end else begin
          last_owner <= 3'b000;
          state <= S_ARB_IDLE;
        end
        default: state <= S_ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_address = grant[0] ? bus.uart_address : grant[1] ? bus.dec_address : grant[2] ? bus.vga_address : 18'h0;
    SRAM_write_data = grant[0] ? bus.uart_write_data : grant[1] ? bus.dec_write_data : 16'h0;
    SRAM_we_n = grant[0] ? bus.uart_we_n : grant[1] ? bus.dec_we_n : 1'b1;
  end

  // {grant, we_n} follows each access through the SRAM read latency
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= 4'h0;
    end else begin
      stage[0] <= {grant, SRAM_we_n};
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign bus.rvalid = stage[READ_LATENCY-1][0] ? stage[READ_LATENCY-1][3:1] : 3'b000;
  assign bus.grant = grant;
  assign arb_busy = state != S_ARB_IDLE;

`ifdef ARB_STATS_EN
  logic [2:0][15:0] wait_cnt, wait_nxt;
  always_comb begin
    for (int i = 0; i < 3; i++) wait_nxt[i] = wait_cnt[i] == 16'hFFFF ? wait_cnt[i] : wait_cnt[i] + 16'd1;
  end
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      grant_cycles <= '0;
      max_wait <= '0;
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (state == S_ARB_OWN && grant[i]) grant_cycles[i] <= grant_cycles[i] + 32'd1;
        wait_cnt[i] <= bus.req[i] && !grant[i] ? wait_nxt[i] : 16'd0;
        if (bus.req[i] && !grant[i] && wait_nxt[i] > max_wait[i]) max_wait[i] <= wait_nxt[i];
      end
    end
  end
`endif
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed checks of grant timing, burst capping, fairness, read tagging and reset.
module tb_sram_access_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic sram_we_n, arb_busy;
`ifdef ARB_STATS_EN
  logic [2:0][31:0] grant_cycles;
  logic [2:0][15:0] max_wait;
`endif

  sram_access_arbiter_if bus();

  sram_access_arbiter #(.READ_LATENCY(2), .MAX_BURST(4)) dut (
    .CLOCK_50_I(clk),
    .resetn(resetn),
    .bus(bus),
    .SRAM_address(sram_address),
    .SRAM_write_data(sram_write_data),
    .SRAM_we_n(sram_we_n),
    .arb_busy(arb_busy)
`ifdef ARB_STATS_EN
    ,
    .grant_cycles(grant_cycles),
    .max_wait(max_wait)
`endif
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req = 3'b000;
    bus.uart_address = 18'h01234;
    bus.uart_write_data = 16'hABCD;
    bus.uart_we_n = 1'b0;
    bus.dec_address = 18'h00200;
    bus.dec_write_data = 16'h5A5A;
    bus.dec_we_n = 1'b1;
    bus.vga_address = 18'h00010;
    #25;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_addr", 32'(sram_address), 32'h0);
    check("rst_wdata", 32'(sram_write_data), 32'h0);
    check("rst_busy", 32'(arb_busy), 32'h0);
    step();
    resetn = 1'b1;
    // all three request together: UART wins one cycle later
    bus.req = 3'b111;
    step();
    check("prio_grant", 32'(bus.grant), 32'h1);
    check("prio_addr", 32'(sram_address), 32'h01234);
    check("prio_wdata", 32'(sram_write_data), 32'hABCD);
    check("prio_we_n0", 32'(sram_we_n), 32'h0);
    check("prio_busy", 32'(arb_busy), 32'h1);
    bus.uart_we_n = 1'b1;
    #1;
    check("prio_we_n1", 32'(sram_we_n), 32'h1);
    bus.uart_we_n = 1'b0;
    bus.req = 3'b000;
    step();
    check("drop_grant", 32'(bus.grant), 32'h0);
    check("drop_we_n", 32'(sram_we_n), 32'h1);
    check("drop_busy", 32'(arb_busy), 32'h1);
    step();
    check("idle_busy", 32'(arb_busy), 32'h0);
    // decoder write enable while UART owns must not reach the SRAM
    bus.dec_we_n = 1'b0;
    bus.uart_we_n = 1'b1;
    bus.req = 3'b011;
    step();
    check("own_grant", 32'(bus.grant), 32'h1);
    check("own_we_n", 32'(sram_we_n), 32'h1);
    check("own_wdata", 32'(sram_write_data), 32'hABCD);
    bus.req = 3'b010;
    step();
    check("turn_grant", 32'(bus.grant), 32'h0);
    check("turn_we_n", 32'(sram_we_n), 32'h1);
    step();
    check("dec_grant", 32'(bus.grant), 32'h2);
    check("dec_we_n", 32'(sram_we_n), 32'h0);
    check("dec_addr", 32'(sram_address), 32'h00200);
    check("dec_wdata", 32'(sram_write_data), 32'h5A5A);
    check("uart_rd_tag", 32'(bus.rvalid), 32'h1);
    bus.req = 3'b000;
    bus.dec_we_n = 1'b1;
    step();
    step();
    // burst cap of 4 with fair hand-over between decoder and VGA
    bus.req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dec_burst", 32'(bus.grant), 32'h2);
    end
    step();
    check("cap_turn", 32'(bus.grant), 32'h0);
    check("cap_we_n", 32'(sram_we_n), 32'h1);
    step();
    check("vga_grant", 32'(bus.grant), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("vga_burst", 32'(bus.grant), 32'h4);
    end
    step();
    check("vga_cap_turn", 32'(bus.grant), 32'h0);
    step();
    check("dec_regrant", 32'(bus.grant), 32'h2);
    bus.req = 3'b000;
    step();
    step();
    check("burst_idle", 32'(arb_busy), 32'h0);
    // single VGA read, then UART writes that must stay untagged
    bus.uart_we_n = 1'b0;
    bus.req = 3'b100;
    step();
    check("vga_issue", 32'(bus.grant), 32'h4);
    check("vga_addr", 32'(sram_address), 32'h00010);
    check("vga_we_n", 32'(sram_we_n), 32'h1);
    bus.req = 3'b001;
    step();
    check("tag_early", 32'(bus.rvalid), 32'h0);
    step();
    check("vga_rvalid", 32'(bus.rvalid), 32'h4);
    check("uart_after", 32'(bus.grant), 32'h1);
    step();
    check("wr_no_tag1", 32'(bus.rvalid), 32'h0);
    step();
    check("wr_no_tag2", 32'(bus.rvalid), 32'h0);
    bus.req = 3'b000;
    step();
    step();
    // reset with decoder reads in flight
    bus.req = 3'b010;
    step();
    step();
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'h0);
    resetn = 1'b0;
    bus.req = 3'b000;
    #1;
    check("mid_rst_grant", 32'(bus.grant), 32'h0);
    check("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("mid_rst_busy", 32'(arb_busy), 32'h0);
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
    end
`ifdef ARB_STATS_EN
    resetn = 1'b0;
    #1;
    check("stat_rst_gc", grant_cycles[0], 32'h0);
    check("stat_rst_mw", 32'(max_wait[2]), 32'h0);
    step();
    resetn = 1'b1;
    bus.req = 3'b001;
    for (int i = 0; i < 10; i++) step();
    bus.req = 3'b000;
    step();
    step();
    check("stat_gc_uart", grant_cycles[0], 32'd10);
    bus.req = 3'b101;
    for (int i = 0; i < 6; i++) step();
    check("stat_vga_grant", 32'(bus.grant), 32'h4);
    check("stat_mw_vga", 32'(max_wait[2]), 32'd6);
    bus.req = 3'b000;
    step();
    step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Owns the single SRAM_Controller port and time-shares it between three requesters: UART receiver (writes), image decoder (Milestone 1/2 read/write) and VGA reader (reads).
- Replaces the top-level combinational SRAM mux keyed on top_state with a registered, request/grant scheduler.
- Provides turnaround cycles, burst capping with fairness, and per-requester read-data-valid tagging.
- The top FSM only raises and drops requests.

Parameters:
- READ_LATENCY, 2, cycles from address issue to valid SRAM_read_data at the controller output.
- MAX_BURST, 64, maximum consecutive owned cycles before forced re-arbitration when another request is pending.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  request vector; bit0 UART, bit1 decoder, bit2 VGA.
- uart_address  in  18  UART SRAM address.
- uart_write_data  in  16  UART write data.
- uart_we_n  in  1  UART write enable, active-low.
- dec_address  in  18  decoder SRAM address.
- dec_write_data  in  16  decoder write data.
- dec_we_n  in  1  decoder write enable, active-low.
- vga_address  in  18  VGA SRAM address; VGA is read-only.
- grant  out  3  one-hot registered grant, same bit order as req.
- rvalid  out  3  one-cycle pulse when SRAM_read_data belongs to requester i.
- SRAM_address  out  18  to SRAM_Controller.
- SRAM_write_data  out  16  to SRAM_Controller.
- SRAM_we_n  out  1  to SRAM_Controller.
- arb_busy  out  1  high in any state other than S_ARB_IDLE.

Behaviour:
- Reset (asynchronous, resetn low): state S_ARB_IDLE, grant=0, rvalid=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, burst_cnt=0, latency pipeline cleared, arb_busy=0. Asserting reset mid-burst aborts immediately; no late rvalid is emitted after reset.
- SRAM_address, SRAM_write_data and SRAM_we_n are combinational muxes selected by the registered grant. With grant=0 they are 0, 0 and 1.
- Non-owner we_n is ignored. VGA always issues reads (SRAM_we_n=1 while the VGA is granted).
- Priority: UART > decoder > VGA. Simultaneous requests in S_ARB_IDLE grant the highest-priority requester.
- S_ARB_IDLE: if req != 0, set grant to the winner and burst_cnt=0 on the next edge, then go to S_ARB_OWN.
- S_ARB_OWN: each cycle is one SRAM access by the owner, and burst_cnt increments. Exit conditions:
  - Owner drops req: grant=0 on the next edge, go to S_ARB_TURN.
  - burst_cnt == MAX_BURST-1 and another req bit is set: preempt. grant=0, remember the preempted owner in last_owner, go to S_ARB_TURN.
  - burst_cnt == MAX_BURST-1 and no other request: stay, and burst_cnt saturates at MAX_BURST-1.
- S_ARB_TURN: exactly one idle cycle (SRAM_we_n=1, grant=0) for bus turnaround.
  - Arbitrate among req, excluding last_owner if any other request is pending; this is the anti-starvation rule.
  - Winner goes to S_ARB_OWN. With no requests, go to S_ARB_IDLE and clear last_owner.
- A requester samples grant[i]. It must hold its address, data and we_n valid whenever req[i]=1, and must tolerate losing grant mid-transfer, then resume at its current address when regranted.
- Read tagging: a READ_LATENCY-deep shift register carries {grant, SRAM_we_n}. rvalid[i] = stage[READ_LATENCY-1] with grant bit i set and we_n=1. Write cycles never produce rvalid.
- rvalid may arrive after grant has already moved to another requester; requesters must accept it regardless of grant.
- No combinational path from req to SRAM_* outputs: grant latency is 1 cycle from req rising in S_ARB_IDLE, and 2 cycles (through S_ARB_TURN) after an ownership change.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds output grant_cycles, 3x32 bits (one counter per requester), incrementing each S_ARB_OWN cycle for the owner. Also adds max_wait, 3x16 bits, the largest observed req-to-grant latency per requester, saturating at 16'hFFFF. All are cleared by reset.
- Not defined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then req=3'b111 in one cycle: grant=3'b001 one cycle later; SRAM_address equals uart_address; SRAM_we_n follows uart_we_n.
- Decoder owns with VGA req held, MAX_BURST=4: decoder gets 4 cycles, then 1 turnaround cycle with SRAM_we_n=1, then grant=3'b100. Decoder is regranted after VGA drops req or VGA hits its own 4-cycle cap.
- VGA read of 18'h00010 in one owned cycle, READ_LATENCY=2: rvalid=3'b100 exactly 2 cycles after the issue cycle. UART write cycles issued in between produce no rvalid.
- UART owns, dec_we_n=0 asserted while not granted: SRAM_we_n tracks only uart_we_n, and no decoder write reaches the SRAM.
- resetn pulsed low while decoder owns with 2 reads in flight: grant=0, SRAM_we_n=1 immediately; no rvalid pulses afterwards.
- With ARB_STATS_EN defined: 10 owned UART cycles give grant_cycles[0]=10. VGA waiting 6 cycles behind the UART gives max_wait[2]=6.
